// File: rtl/toggle_rx.sv
// Toggle-encoded event receiver. TIN is synchronized and each level change
// becomes one event. Events accumulate in a saturating pending counter that
// a consumer drains through a VALID/READY handshake. A sticky OVF flag marks
// any event lost while the counter was full.
module toggle_rx #(
  parameter int CNT_W = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             TIN,
  input  logic             READY,
  input  logic             CLR,
  output logic             EVT,
  output logic             VALID,
  output logic [CNT_W-1:0] COUNT,
  output logic             FULL,
  output logic             OVF
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Occupancy is a pure decode of the counter, so no separate state register.
  typedef enum logic [1:0] {OCC_EMPTY, OCC_PENDING, OCC_FULL} occ_e;

  logic             s1_q, s2_q, s3_q;
  logic             evt_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             det;
  logic             pop;
  occ_e             occ;

  // Two-flop synchronizer plus history flop; CLR deliberately leaves these alone.
  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      s3_q  <= 1'b0;
      evt_q <= 1'b0;
    end else begin
      s1_q  <= TIN;
      s2_q  <= s1_q;
      s3_q  <= s2_q;
      evt_q <= det;
    end
  end

  // Both edges of the synchronized line count as an event.
  assign det = s2_q ^ s3_q;

  // Decode occupancy from the current count.
  always_comb begin
    occ = OCC_PENDING;
    if (count_q == '0)          occ = OCC_EMPTY;
    else if (count_q == CNT_MAX) occ = OCC_FULL;
  end

  assign VALID = (occ != OCC_EMPTY);
  assign FULL  = (occ == OCC_FULL);
  assign pop   = VALID & READY;

  // Counter next state: saturate at max (flag overflow), never go below zero.
  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    if (CLR) begin
      count_d = '0;
      ovf_d   = 1'b0;
    end else begin
      unique case ({det, pop})
        2'b10: begin
          if (occ == OCC_FULL) ovf_d   = 1'b1;
          else                 count_d = count_q + CNT_ONE;
        end
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // Counter and overflow registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign EVT   = evt_q;
  assign COUNT = count_q;
  assign OVF   = ovf_q;

endmodule

// File: tb/tb_toggle_rx.sv
// Self-checking bench for toggle_rx: a vector table for reset and basic
// behaviour, hand-written sequences for saturation, clear and reset corners,
// and an event scoreboard predicting when each EVT pulse must appear.
module tb_toggle_rx;

  localparam int CNT_W = 4;
  localparam int MAXC  = 15;

  logic             CLK = 1'b0;
  logic             RST, TIN, READY, CLR;
  logic             EVT, VALID, FULL, OVF;
  logic [CNT_W-1:0] COUNT;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int evq[$];

  toggle_rx #(.CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST), .TIN(TIN), .READY(READY), .CLR(CLR),
    .EVT(EVT), .VALID(VALID), .COUNT(COUNT), .FULL(FULL), .OVF(OVF)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit tin; bit ready; bit clr; bit rst;
    int count; bit ovf;
  } vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  // One clock: drive before the edge, record predicted EVT timing, then
  // compare EVT against the scoreboard just after the edge.
  task automatic step(input bit tin, input bit ready, input bit clr, input bit rst);
    int  e;
    bit  exp_evt;
    @(negedge CLK);
    e = cyc;
    if (rst) evq.delete();
    else if (tin != TIN) evq.push_back(e + 2);
    TIN = tin; READY = ready; CLR = clr; RST = rst;
    @(posedge CLK);
    #1;
    exp_evt = 1'b0;
    if (evq.size() > 0 && evq[0] == e) begin
      exp_evt = 1'b1;
      void'(evq.pop_front());
    end
    chk("evt", int'(EVT), int'(exp_evt));
    cyc++;
  endtask

  task automatic chk_out(input string nm, input int c, input bit o);
    chk({nm, ".count"}, int'(COUNT), c);
    chk({nm, ".valid"}, int'(VALID), int'(c != 0));
    chk({nm, ".full"},  int'(FULL),  int'(c == MAXC));
    chk({nm, ".ovf"},   int'(OVF),   int'(o));
  endtask

  vec_t vecs[13];

  initial begin
    RST = 1'b1; TIN = 1'b0; READY = 1'b0; CLR = 1'b0;

    //          tin ready clr rst count ovf
    vecs[0]  = '{0, 0, 0, 1, 0, 0};
    vecs[1]  = '{0, 0, 0, 1, 0, 0};
    vecs[2]  = '{0, 0, 0, 0, 0, 0};
    vecs[3]  = '{1, 0, 0, 0, 0, 0};  // rising TIN
    vecs[4]  = '{1, 0, 0, 0, 0, 0};
    vecs[5]  = '{1, 0, 0, 0, 1, 0};  // event lands two edges later
    vecs[6]  = '{1, 0, 0, 0, 1, 0};
    vecs[7]  = '{1, 1, 0, 0, 0, 0};  // pop
    vecs[8]  = '{1, 1, 0, 0, 0, 0};  // READY while empty
    vecs[9]  = '{0, 0, 0, 0, 0, 0};  // falling TIN
    vecs[10] = '{0, 0, 0, 0, 0, 0};
    vecs[11] = '{0, 1, 0, 0, 1, 0};  // event with READY but empty: no pop
    vecs[12] = '{0, 0, 1, 0, 0, 0};  // clear

    foreach (vecs[i]) begin
      step(vecs[i].tin, vecs[i].ready, vecs[i].clr, vecs[i].rst);
      chk_out($sformatf("vec%0d", i), vecs[i].count, vecs[i].ovf);
    end

    // Three spaced toggles, then drain.
    for (int i = 0; i < 3; i++) begin
      step(~TIN, 0, 0, 0);
      repeat (3) step(TIN, 0, 0, 0);
      chk_out($sformatf("fill%0d", i), i + 1, 0);
    end
    for (int i = 0; i < 3; i++) begin
      step(TIN, 1, 0, 0);
      chk_out($sformatf("drain%0d", i), 2 - i, 0);
    end

    // Fill to saturation.
    for (int i = 1; i <= MAXC; i++) begin
      step(~TIN, 0, 0, 0);
      repeat (2) step(TIN, 0, 0, 0);
      chk_out($sformatf("sat%0d", i), i, 0);
    end

    // Event and pop together while full: count and OVF hold.
    step(~TIN, 0, 0, 0);
    step(TIN, 0, 0, 0);
    step(TIN, 1, 0, 0);
    chk_out("full_evt_pop", MAXC, 0);

    // Event while full with no pop: lost, OVF set, no wrap.
    step(~TIN, 0, 0, 0);
    repeat (2) step(TIN, 0, 0, 0);
    chk_out("overflow", MAXC, 1);
    step(TIN, 1, 0, 0);
    chk_out("pop_after_ovf", MAXC - 1, 1);

    // Drain fully, then READY while empty.
    repeat (MAXC - 1) step(TIN, 1, 0, 0);
    chk_out("drained", 0, 1);
    for (int i = 0; i < 5; i++) begin
      step(TIN, 1, 0, 0);
      chk_out($sformatf("empty_ready%0d", i), 0, 1);
    end
    step(TIN, 0, 1, 0);
    chk_out("clr_ovf", 0, 0);

    // CLR in the cycle an event is detected: counter discards it, EVT still pulses.
    step(~TIN, 0, 0, 0);
    step(TIN, 0, 0, 0);
    step(TIN, 0, 1, 0);
    chk_out("clr_discard", 0, 0);
    step(TIN, 0, 0, 0);
    chk_out("clr_discard_after", 0, 0);

    // Build up some count, then reset one cycle after a toggle.
    for (int i = 0; i < 2; i++) begin
      step(~TIN, 0, 0, 0);
      repeat (2) step(TIN, 0, 0, 0);
    end
    chk_out("pre_rst", 2, 0);
    step(~TIN, 0, 0, 0);
    step(1'b0, 0, 0, 1);
    chk_out("rst", 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 0, 0, 0);
      chk_out($sformatf("post_rst%0d", i), 0, 0);
    end

    // TIN high after reset release is one event.
    step(1'b1, 0, 0, 0);
    repeat (2) step(1'b1, 0, 0, 0);
    chk_out("resume", 1, 0);
    step(1'b1, 0, 0, 0);
    chk_out("resume_hold", 1, 0);

    chk("evq_empty", evq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
